hs_npu_exec_queue: RTL and testbench

Parametrised successor to the NPU executive. Validates layer configurations captured from the CSR block and queues them as jobs. Dispatches queued jobs one at a time to the memory ordering unit with a valid/ready handshake. Tracks completion with a watchdog and reports per-job exit codes plus a maskable, sticky interrupt.

---
 rtl/hs_npu_exec_queue.sv | 151 +++++++++++++++
 tb/tb_hs_npu_exec_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_exec_queue.sv
// rtl/hs_npu_exec_queue.sv - NPU job admission queue, dispatcher, watchdog and exit/irq reporting
module hs_npu_exec_queue #(
    parameter int DATA_W         = 32,
    parameter int DIM_W          = 8,
    parameter int MAX_DIM        = 8,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [4*DIM_W-1:0]                cfg_dims_i,
    input  logic [5:0]                        cfg_flags_i,
    input  logic [4:0]                        cfg_shift_i,
    input  logic [DATA_W-1:0]                 cfg_base_addr_i,
    input  logic [DATA_W-1:0]                 cfg_res_addr_i,
    input  logic                              irq_en_i,
    input  logic                              irq_clr_i,
    input  logic                              job_ready_i,
    input  logic                              job_finished_i,
    output logic                              job_valid_o,
    output logic [4*DIM_W+11+2*DATA_W-1:0]    job_o,
    output logic                              job_abort_o,
    output logic                              init_clr_o,
    output logic [2:0]                        exit_code_o,
    output logic                              exit_valid_o,
    output logic                              busy_o,
    output logic [$clog2(QUEUE_DEPTH):0]      queue_count_o,
    output logic                              irq
);
    localparam int PAY_W  = 4*DIM_W + 11 + 2*DATA_W;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [DIM_W-1:0] MAX_D   = DIM_W'(MAX_DIM);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WD_LIM);

    localparam logic [2:0] EC_OK      = 3'd1;
    localparam logic [2:0] EC_BADDIM  = 3'd2;
    localparam logic [2:0] EC_OVFL    = 3'd3;
    localparam logic [2:0] EC_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

    state_t             state, next_state;
    logic [PAY_W-1:0]   mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [PAY_W-1:0]   job_q;
    logic [WD_W-1:0]    wd;
    logic               irq_pending;

    logic [DIM_W-1:0]   in_rows, in_cols, wght_rows, wght_cols;
    logic               dims_bad, fifo_full, push, reject;
    logic               pop, job_done, job_timeout;

    assign in_rows   = cfg_dims_i[4*DIM_W-1 -: DIM_W];
    assign in_cols   = cfg_dims_i[3*DIM_W-1 -: DIM_W];
    assign wght_rows = cfg_dims_i[2*DIM_W-1 -: DIM_W];
    assign wght_cols = cfg_dims_i[DIM_W-1:0];

    assign dims_bad = (in_rows == '0) || (in_cols == '0) || (wght_rows == '0) || (wght_cols == '0)
                   || (in_rows > MAX_D) || (in_cols > MAX_D) || (wght_rows > MAX_D) || (wght_cols > MAX_D)
                   || (in_cols != wght_rows);
    // Fullness uses pre-pop occupancy so a same-cycle pop never makes room
    assign fifo_full = (count == FULL_C);
    assign push      = start_i && !dims_bad && !fifo_full;
    assign reject    = start_i && (dims_bad || fifo_full);

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        job_done    = 1'b0;
        job_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (job_ready_i) next_state = S_RUN;
            end
            S_RUN: begin
                if (job_finished_i) begin
                    next_state = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (wd == WD_LAST)) begin
                    job_timeout = 1'b1;
                    next_state  = S_IDLE;
                end
            end
            S_DONE: begin
                job_done   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cfg_dims_i, cfg_flags_i, cfg_shift_i, cfg_base_addr_i, cfg_res_addr_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            job_q        <= '0;
            wd           <= '0;
            init_clr_o   <= 1'b0;
            job_abort_o  <= 1'b0;
            exit_code_o  <= 3'd0;
            exit_valid_o <= 1'b0;
            irq_pending  <= 1'b0;
        end else begin
            init_clr_o  <= start_i;
            job_abort_o <= job_timeout;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                job_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (state == S_ISSUE)    wd <= '0;
            else if (state == S_RUN) wd <= wd + WD_W'(1);
            // A job result outranks a same-cycle rejection code; both share one pulse
            if (job_done)         exit_code_o <= EC_OK;
            else if (job_timeout) exit_code_o <= EC_TIMEOUT;
            else if (reject)      exit_code_o <= dims_bad ? EC_BADDIM : EC_OVFL;
            exit_valid_o <= job_done || job_timeout || reject;
            if (job_done || job_timeout || reject) irq_pending <= 1'b1;
            else if (irq_clr_i)                    irq_pending <= 1'b0;
        end
    end

    assign job_valid_o   = (state == S_ISSUE);
    assign job_o         = job_q;
    assign busy_o        = (state != S_IDLE) || (count != '0);
    assign queue_count_o = count;
    assign irq           = irq_pending && irq_en_i;
endmodule

// File: tb/tb_hs_npu_exec_queue.sv
// tb/tb_hs_npu_exec_queue.sv - scoreboard bench for hs_npu_exec_queue
module tb_hs_npu_exec_queue;
    localparam int DATA_W = 32, DIM_W = 8, MAX_DIM = 8, QD = 4, TMO = 16;
    localparam int PAY_W = 4*DIM_W + 11 + 2*DATA_W;
    localparam int DOFF  = PAY_W - 4*DIM_W;

    logic clk = 0, rst_n = 0, start = 0, irq_en = 1, irq_clr = 0, ready = 0, finished = 0;
    logic [PAY_W-1:0] cfg_bus = '0;
    logic [4*DIM_W-1:0] cfg_dims;
    logic [5:0] cfg_flags;
    logic [4:0] cfg_shift;
    logic [DATA_W-1:0] cfg_base, cfg_res;
    logic job_valid, job_abort, init_clr, exit_valid, busy, irq;
    logic [PAY_W-1:0] job;
    logic [2:0] exit_code;
    logic [$clog2(QD):0] qcount;

    assign {cfg_dims, cfg_flags, cfg_shift, cfg_base, cfg_res} = cfg_bus;

    hs_npu_exec_queue #(.DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_DIM(MAX_DIM),
                        .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .cfg_dims_i(cfg_dims),
        .cfg_flags_i(cfg_flags), .cfg_shift_i(cfg_shift), .cfg_base_addr_i(cfg_base),
        .cfg_res_addr_i(cfg_res), .irq_en_i(irq_en), .irq_clr_i(irq_clr),
        .job_ready_i(ready), .job_finished_i(finished), .job_valid_o(job_valid),
        .job_o(job), .job_abort_o(job_abort), .init_clr_o(init_clr),
        .exit_code_o(exit_code), .exit_valid_o(exit_valid), .busy_o(busy),
        .queue_count_o(qcount), .irq(irq));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int aborts_seen = 0, exp_aborts = 0;
    logic [PAY_W-1:0] exp_jobs[$];
    logic [2:0]       exp_exits[$];
    logic             stall_prev = 0;
    logic [PAY_W-1:0] last_job;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit dims_ok(input logic [PAY_W-1:0] p);
        int a, b, c, d;
        a = int'(p[DOFF+24 +: 8]); b = int'(p[DOFF+16 +: 8]);
        c = int'(p[DOFF+8 +: 8]);  d = int'(p[DOFF +: 8]);
        return a >= 1 && a <= MAX_DIM && b >= 1 && b <= MAX_DIM && c >= 1 && c <= MAX_DIM
            && d >= 1 && d <= MAX_DIM && b == c;
    endfunction

    function automatic logic [PAY_W-1:0] mk(input int a, input int b, input int c, input int d);
        logic [5:0] f; logic [4:0] s; logic [31:0] ba, ra;
        f = 6'($urandom); s = 5'($urandom); ba = $urandom; ra = $urandom;
        return {8'(a), 8'(b), 8'(c), 8'(d), f, s, ba, ra};
    endfunction

    // Monitor: consumes expectations whenever the DUT dispatches or reports
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev && job_valid) check("job_stable", job, last_job);
            if (job_valid && ready) begin
                if (exp_jobs.size() == 0) check("dispatch_unexpected", job_valid & ready, 0);
                else check("dispatch_payload", job, exp_jobs.pop_front());
            end
            if (exit_valid) begin
                if (exp_exits.size() == 0) check("exit_unexpected", exit_valid, 0);
                else begin
                    logic [2:0] e;
                    e = exp_exits.pop_front();
                    check("exit_code", exit_code, e);
                    if (e == 3'd4) check("abort_with_timeout", job_abort, 1);
                end
            end
            if (job_abort) aborts_seen++;
            stall_prev = job_valid && !ready;
            last_job   = job;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [PAY_W-1:0] p, input bit full);
        cfg_bus = p;
        start = 1;
        if (!dims_ok(p))  exp_exits.push_back(3'd2);
        else if (full)    exp_exits.push_back(3'd3);
        else              exp_jobs.push_back(p);
        tick();
        start = 0;
        check("init_clr", init_clr, 1);
    endtask

    // k = RUN cycle (0-based) in which finished is pulsed; k >= TMO means the watchdog wins
    task automatic run_job(input int rdy_delay, input int k);
        int n = 0;
        while (!job_valid && n < 30) begin tick(); n++; end
        if (!job_valid) begin check("job_valid_wait", job_valid, 1); return; end
        repeat (rdy_delay) tick();
        ready = 1;
        tick();
        ready = 0;
        if (k < TMO) exp_exits.push_back(3'd1);
        else begin exp_exits.push_back(3'd4); exp_aborts++; end
        repeat (k) tick();
        finished = 1;
        tick();
        finished = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic [PAY_W-1:0] p;
        repeat (3) tick();
        rst_n = 1;
        check("rst_qcount", qcount, 0);
        check("rst_valid", job_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_irq", irq, 0);

        // latency and basic completion
        p = mk(4, 4, 4, 2);
        cfg_bus = p; start = 1; exp_jobs.push_back(p);
        tick(); start = 0;
        check("lat_init_clr", init_clr, 1);
        check("lat_qcount", qcount, 1);
        tick();
        check("lat_valid", job_valid, 1);
        run_job(0, 4);
        tick();
        check("ok_code", exit_code, 1);
        check("ok_irq", irq, 1);
        irq_clr = 1; tick(); irq_clr = 0;
        check("irq_cleared", irq, 0);

        // bad dimensions
        do_start(mk(4, 3, 4, 2), 0);
        check("bad_mismatch_code", exit_code, 2);
        do_start(mk(0, 4, 4, 2), 0);
        check("bad_zero_code", exit_code, 2);
        do_start(mk(4, 4, 4, 9), 0);
        check("bad_big_code", exit_code, 2);
        repeat (3) tick();
        check("bad_qcount", qcount, 0);
        check("bad_no_valid", job_valid, 0);

        // fill and overflow with the consumer stalled
        do_start(mk(2, 2, 2, 2), 0);
        tick(); tick();
        for (int i = 0; i < 4; i++) do_start(mk(1 + i, 3, 3, 8 - i), 0);
        check("fill_count", qcount, QD);
        do_start(mk(5, 5, 5, 5), 1);
        check("ovfl_code", exit_code, 3);
        check("ovfl_count", qcount, QD);
        repeat (5) tick();
        for (int i = 0; i < 5; i++) run_job($urandom_range(0, 3), $urandom_range(0, 8));
        repeat (3) tick();
        check("drain_busy", busy, 0);

        // watchdog expiry then next job; late finished ignored
        do_start(mk(3, 2, 2, 1), 0);
        do_start(mk(1, 1, 1, 1), 0);
        run_job(0, 20);
        run_job(0, 3);
        repeat (3) tick();

        // finished on the expiry cycle; clr and a rejection coincide with completion
        check("irq_before", irq, 1);
        do_start(mk(6, 7, 7, 8), 0);
        run_job(1, TMO - 1);
        cfg_bus = mk(9, 1, 1, 1); start = 1; irq_clr = 1;
        tick();
        start = 0; irq_clr = 0;
        check("merge_init_clr", init_clr, 1);
        check("merge_code", exit_code, 1);
        check("merge_irq", irq, 1);
        repeat (3) tick();

        // randomized single-outstanding traffic
        for (int i = 0; i < 40; i++) begin
            int a, b, c, d;
            a = $urandom_range(1, 8); b = $urandom_range(1, 8); c = b; d = $urandom_range(1, 8);
            case ($urandom_range(0, 5))
                0: a = 0;
                1: d = $urandom_range(9, 255);
                2: c = (b % 8) + 1;
                default: ;
            endcase
            p = mk(a, b, c, d);
            do_start(p, 0);
            if (dims_ok(p)) run_job($urandom_range(0, 3), $urandom_range(0, 20));
            repeat (3) tick();
        end

        // reset during RUN with jobs queued
        for (int i = 0; i < 3; i++) do_start(mk(2, 4, 4, 2), 0);
        while (!job_valid) tick();
        ready = 1; tick(); ready = 0;
        tick(); tick();
        rst_n = 0; tick();
        exp_jobs.delete();
        check("rr_qcount", qcount, 0);
        check("rr_valid", job_valid, 0);
        check("rr_busy", busy, 0);
        check("rr_abort", job_abort, 0);
        check("rr_exit_code", exit_code, 0);
        check("rr_irq", irq, 0);
        rst_n = 1;
        repeat (25) tick();
        check("post_rr_qcount", qcount, 0);

        check("exits_drained", exp_exits.size(), 0);
        check("jobs_drained", exp_jobs.size(), 0);
        check("abort_count", aborts_seen, exp_aborts);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
